// File: rtl/modo_cbc.sv
// CBC-mode front end for an AES-128 cipher core: packs bytes into blocks, applies
// PKCS#7 padding, XORs with the chaining value and returns ciphertext via valid/ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   iv, iniciar              initial chaining value, message start (idle only)
//   in_byte/valid/last/ready plaintext byte stream
//   cifra_bloco/cifra_saida  registered cipher input, combinational cipher output
//   out_bloco/valid/ready    ciphertext block handshake
//   out_last                 final block of the message
//   ocupado                  busy (any state but idle)
module modo_cbc #(
    parameter int LAT_CIFRA = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] iv,
    input  logic         iniciar,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [127:0] cifra_bloco,
    input  logic [127:0] cifra_saida,
    output logic [127:0] out_bloco,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         ocupado
);

    localparam int LW = (LAT_CIFRA > 1) ? $clog2(LAT_CIFRA) : 1;

    typedef enum logic [1:0] {
        OCIOSO,
        ACUMULA,
        CIFRA,
        SAIDA
    } estado_t;

    estado_t        estado;
    estado_t        estado_n;
    logic [127:0]   blk;
    logic [127:0]   blk_full;
    logic [127:0]   chain;
    logic [3:0]     cnt;
    logic [7:0]     pad_val;
    logic           fim;
    logic           pad_pendente;
    logic [LW-1:0]  lat_cnt;
    logic           lat_fim;
    logic           aceita;
    logic           fecha;
    logic           hs;

    assign lat_fim = (lat_cnt == LW'(LAT_CIFRA - 1));

    // Block as it looks with the current byte merged in; when this byte is
    // the last one, every later slot carries the PKCS#7 pad value.
    always_comb begin
        pad_val  = 8'd15 - {4'd0, cnt};
        blk_full = blk;
        for (int i = 0; i < 16; i++) begin
            if (i == int'(cnt))
                blk_full[127-8*i -: 8] = in_byte;
            else if (i > int'(cnt) && in_last)
                blk_full[127-8*i -: 8] = pad_val;
        end
    end

    always_comb begin
        estado_n  = estado;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        ocupado   = 1'b1;
        aceita    = 1'b0;
        fecha     = 1'b0;
        hs        = 1'b0;
        unique case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (iniciar)
                    estado_n = ACUMULA;
            end
            ACUMULA: begin
                in_ready = 1'b1;
                aceita   = in_valid;
                fecha    = in_valid & (in_last | (cnt == 4'd15));
                if (fecha)
                    estado_n = CIFRA;
            end
            CIFRA: begin
                if (lat_fim)
                    estado_n = SAIDA;
            end
            SAIDA: begin
                out_valid = 1'b1;
                out_last  = fim & ~pad_pendente;
                hs        = out_ready;
                if (out_ready) begin
                    if (pad_pendente)
                        estado_n = CIFRA;
                    else if (fim)
                        estado_n = OCIOSO;
                    else
                        estado_n = ACUMULA;
                end
            end
            default: estado_n = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado       <= OCIOSO;
            blk          <= '0;
            chain        <= '0;
            cnt          <= '0;
            fim          <= 1'b0;
            pad_pendente <= 1'b0;
            lat_cnt      <= '0;
            cifra_bloco  <= '0;
            out_bloco    <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        chain        <= iv;
                        cnt          <= '0;
                        fim          <= 1'b0;
                        pad_pendente <= 1'b0;
                    end
                end
                ACUMULA: begin
                    if (aceita) begin
                        blk <= blk_full;
                        cnt <= cnt + 4'd1;
                    end
                    // Load the cipher input on the same edge the block completes
                    // so the cipher sees it for exactly LAT_CIFRA cycles.
                    if (fecha) begin
                        cifra_bloco <= blk_full ^ chain;
                        lat_cnt     <= '0;
                        if (in_last && cnt == 4'd15)
                            pad_pendente <= 1'b1;
                        else if (in_last)
                            fim <= 1'b1;
                    end
                end
                CIFRA: begin
                    if (lat_fim)
                        out_bloco <= cifra_saida;
                    else
                        lat_cnt <= lat_cnt + LW'(1);
                end
                SAIDA: begin
                    if (hs) begin
                        chain <= out_bloco;
                        if (pad_pendente) begin
                            // Full pad block, chained on the block just emitted.
                            cifra_bloco  <= {16{8'h10}} ^ out_bloco;
                            lat_cnt      <= '0;
                            pad_pendente <= 1'b0;
                            fim          <= 1'b1;
                        end else if (fim) begin
                            fim <= 1'b0;
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
            estado <= estado_n;
        end
    end

endmodule
